// File: rtl/pb_timer_pkg.sv
// Shared register map and bit positions for the KCPSM6 timer peripheral.
package pb_timer_pkg;

  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_STATUS    = 3'd1;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd2;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd3;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd5;
  localparam logic [2:0] OFF_PRESCALE  = 3'd6;
  localparam logic [2:0] OFF_ID        = 3'd7;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_LOAD = 3;

  localparam int ST_EXP = 0;
  localparam int ST_OVR = 1;

endpackage

// File: rtl/pb_timer_peripheral_if.sv
// KCPSM6 I/O port bus as seen by one register-mapped responder.
interface pb_timer_peripheral_if;

  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  modport master (
    output port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, out_port, write_strobe, read_strobe, interrupt_ack,
    output in_port, interrupt
  );

endinterface

// File: rtl/pb_timer_prescaler.sv
// Divides clk by prescale+1 while enabled; tick_en is combinational from pcnt.
// Holds when disabled; clear restarts the division from zero.
module pb_timer_prescaler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] prescale,
  output logic       tick_en
);

  logic [7:0] pcnt_q, pcnt_d;

  assign tick_en = enable && (pcnt_q == prescale);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clear) begin
      pcnt_d = 8'h00;
    end else if (tick_en) begin
      pcnt_d = 8'h00;
    end else if (enable) begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q <= 8'h00;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pb_timer_peripheral.sv
// 16-bit down-counting timer with prescaler on the KCPSM6 port bus.
// Reads return one cycle after port_id is presented; writes act on the strobe edge; no backpressure.
module pb_timer_peripheral
  import pb_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10,
  parameter logic [7:0] ID_VALUE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pb_timer_peripheral_if.slave  bus,
  output logic                  timer_tick
);

  logic        hit, wr_en, load, tick_en, expire;
  logic [2:0]  off;
  logic [7:0]  rd_dat;

  logic        en_q, en_d, auto_q, auto_d, ie_q, ie_d;
  logic        exp_q, exp_d, ovr_q, ovr_d, irq_q, irq_d;
  logic [15:0] reload_q, reload_d, count_q, count_d;
  logic [7:0]  prescale_q, prescale_d, snap_hi_q, snap_hi_d, in_port_q, in_port_d;

  assign hit   = (bus.port_id[7:3] == BASE_ADDR[7:3]);
  assign off   = bus.port_id[2:0];
  assign wr_en = bus.write_strobe & hit;
  assign load  = wr_en && (off == OFF_CTRL) && bus.out_port[CTRL_LOAD];

  pb_timer_prescaler u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (en_q),
    .clear    (load),
    .prescale (prescale_q),
    .tick_en  (tick_en)
  );

  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    ie_d       = ie_q;
    exp_d      = exp_q;
    ovr_d      = ovr_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    snap_hi_d  = snap_hi_q;
    expire     = 1'b0;

    // Clears are applied first so that an expiry in the same cycle overrides them.
    if (bus.interrupt_ack) begin
      exp_d = 1'b0;
    end
    if (wr_en && (off == OFF_STATUS)) begin
      if (bus.out_port[ST_EXP]) exp_d = 1'b0;
      if (bus.out_port[ST_OVR]) ovr_d = 1'b0;
    end

    if (load) begin
      count_d = reload_q;
    end else if (tick_en) begin
      if (count_q != 16'h0000) begin
        count_d = count_q - 16'd1;
      end else begin
        expire = 1'b1;
        exp_d  = 1'b1;
        if (exp_q) ovr_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end
    end

    if (wr_en) begin
      case (off)
        OFF_CTRL: begin
          en_d   = bus.out_port[CTRL_EN];
          auto_d = bus.out_port[CTRL_AUTO];
          ie_d   = bus.out_port[CTRL_IE];
        end
        OFF_RELOAD_LO: reload_d[7:0]  = bus.out_port;
        OFF_RELOAD_HI: reload_d[15:8] = bus.out_port;
        OFF_PRESCALE:  prescale_d     = bus.out_port;
        default: ;
      endcase
    end

    // Snapshot lets software read a coherent 16-bit count low byte first.
    if (bus.read_strobe && hit && (off == OFF_COUNT_LO)) begin
      snap_hi_d = count_q[15:8];
    end
  end

  always_comb begin
    rd_dat = 8'h00;
    case (off)
      OFF_CTRL: begin
        rd_dat[CTRL_EN]   = en_q;
        rd_dat[CTRL_AUTO] = auto_q;
        rd_dat[CTRL_IE]   = ie_q;
      end
      OFF_STATUS: begin
        rd_dat[ST_EXP] = exp_q;
        rd_dat[ST_OVR] = ovr_q;
      end
      OFF_RELOAD_LO: rd_dat = reload_q[7:0];
      OFF_RELOAD_HI: rd_dat = reload_q[15:8];
      OFF_COUNT_LO:  rd_dat = count_q[7:0];
      OFF_COUNT_HI:  rd_dat = snap_hi_q;
      OFF_PRESCALE:  rd_dat = prescale_q;
      OFF_ID:        rd_dat = ID_VALUE;
      default:       rd_dat = 8'h00;
    endcase
  end

  assign in_port_d = hit ? rd_dat : 8'h00;
  assign irq_d     = ie_d & exp_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      ie_q       <= 1'b0;
      exp_q      <= 1'b0;
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
      reload_q   <= 16'h0000;
      count_q    <= 16'h0000;
      prescale_q <= 8'h00;
      snap_hi_q  <= 8'h00;
      in_port_q  <= 8'h00;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      ie_q       <= ie_d;
      exp_q      <= exp_d;
      ovr_q      <= ovr_d;
      irq_q      <= irq_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      snap_hi_q  <= snap_hi_d;
      in_port_q  <= in_port_d;
    end
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = irq_q;
  assign timer_tick    = expire;

endmodule
